stopwatch_bcd_display: RTL and testbench

//  Display stage downstream of the centisecond stopwatch counter. Takes its binary tick count,

---
 rtl/stopwatch_bcd_display_pkg.sv | 42 ++++
 rtl/stopwatch_bcd_display_seg7_scan.sv | 66 ++++++
 rtl/stopwatch_bcd_display.sv | 108 ++++++++++
 tb/tb_stopwatch_bcd_display.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_bcd_display_pkg.sv
// Shared definitions for the stopwatch display stage: conversion FSM state
// encoding and the active-low 7-segment glyph table.
package stopwatch_bcd_display_pkg;

  // Conversion FSM states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  // Segment patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // BCD digit to segment pattern; non-decimal codes blank the digit
  function automatic logic [6:0] seg7_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_display_seg7_scan.sv
// Multiplexed 7-segment scanner: a prescaler sets the dwell per digit, the
// scan index walks digit 0..DIGITS-1, and anode/segment drives are registered.
module stopwatch_bcd_display_seg7_scan
  import stopwatch_bcd_display_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 50000,
  parameter int DP_POS   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   i_bcd,
  output logic [DIGITS-1:0]     o_an,
  output logic [7:0]            o_seg
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0] r_pre;
  logic [IW-1:0] r_idx;
  logic [3:0]    w_digit;
  logic          w_dp_n;
  logic          w_wrap;

  assign w_wrap = (r_pre == PW'(SCAN_DIV - 1));

  // Select the BCD nibble addressed by the scan index
  always_comb begin
    w_digit = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_idx == IW'(d)) w_digit = i_bcd[d*4 +: 4];
    end
  end

  // Decimal point lit only on the seconds/centiseconds boundary digit
  always_comb begin
    w_dp_n = 1'b1;
    if ((DP_POS < DIGITS) && (r_idx == IW'(DP_POS))) w_dp_n = 1'b0;
  end

  // Dwell prescaler and scan index advance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_pre <= '0;
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Registered display drives from the current index and displayed BCD
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_an  <= ~DIGITS'(1);
      o_seg <= {(DP_POS == 0) ? 1'b0 : 1'b1, seg7_code(4'd0)};
    end else begin
      o_an  <= ~(DIGITS'(1) << r_idx);
      o_seg <= {w_dp_n, seg7_code(w_digit)};
    end
  end

endmodule

// File: rtl/stopwatch_bcd_display.sv
// Stopwatch display stage: snapshots the binary centisecond count whenever it
// changes, converts it to packed BCD with a sequential shift-add-3 engine, and
// feeds the result to the multiplexed 7-segment scanner.
module stopwatch_bcd_display
  import stopwatch_bcd_display_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 50000,
  parameter int DP_POS   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IN_W-1:0]       count_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  ovf_o,
  output logic [DIGITS-1:0]     an_o,
  output logic [7:0]            seg_o
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int BW = 4 * DIGITS;

  logic [1:0]              r_state;
  logic [IN_W-1:0]         r_snap;
  logic [IN_W-1:0]         r_bin;
  logic [DIGITS-1:0][3:0]  r_work;
  logic                    r_flag;
  logic [CW-1:0]           r_cnt;

  logic [DIGITS-1:0][3:0]  w_adj;
  logic [BW-1:0]           w_adj_f;
  logic [BW-1:0]           w_shift;
  logic                    w_carry;
  logic                    w_last;

  // Add-3 correction on every digit that would reach 10+ after doubling
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    always_comb begin
      w_adj[g] = (r_work[g] >= 4'd5) ? r_work[g] + 4'd3 : r_work[g];
    end
  end

  // Bit leaving the top digit is worth 10**DIGITS: that is the overflow carry
  assign w_adj_f = w_adj;
  assign w_carry = w_adj_f[BW-1];
  assign w_shift = {w_adj_f[BW-2:0], r_bin[IN_W-1]};
  assign w_last  = (r_cnt == CW'(IN_W - 1));
  assign busy_o  = (r_state != S_IDLE);

  // Conversion FSM and double-dabble datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_bin   <= '0;
      r_work  <= '0;
      r_flag  <= 1'b0;
      r_cnt   <= '0;
      bcd_o   <= '0;
      ovf_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (count_i != r_snap) begin
            r_snap  <= count_i;
            r_bin   <= count_i;
            r_work  <= '0;
            r_flag  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work <= w_shift;
          r_bin  <= {r_bin[IN_W-2:0], 1'b0};
          if (w_carry) r_flag <= 1'b1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) r_state <= S_LOAD;
        end
        S_LOAD: begin
          bcd_o   <= r_work;
          ovf_o   <= r_flag;
          valid_o <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  stopwatch_bcd_display_seg7_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .DP_POS   (DP_POS)
  ) u_scan (
    .clock (clock),
    .reset (reset),
    .i_bcd (bcd_o),
    .o_an  (an_o),
    .o_seg (seg_o)
  );

endmodule

// File: tb/tb_stopwatch_bcd_display.sv
// Scoreboard bench for the stopwatch BCD display stage.
module tb_stopwatch_bcd_display;

  localparam int IN_W     = 16;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int DP_POS   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] count_i = '0;
  logic [15:0] bcd_o;
  logic        valid_o, busy_o, ovf_o;
  logic [3:0]  an_o;
  logic [7:0]  seg_o;

  stopwatch_bcd_display #(
    .IN_W(IN_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DP_POS(DP_POS)
  ) dut (
    .clock(clock), .reset(reset), .count_i(count_i),
    .bcd_o(bcd_o), .valid_o(valid_o), .busy_o(busy_o), .ovf_o(ovf_o),
    .an_o(an_o), .seg_o(seg_o)
  );

  always #5 clock = ~clock;

  typedef struct { logic [15:0] bcd; logic ovf; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int valid_seen = 0;
  int model_snap = 0;

  // Reference: decimal digits of value mod 10**DIGITS
  function automatic logic [15:0] model_bcd(input int v);
    int m;
    logic [15:0] r;
    m = v % 10000;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_seg(input int dig, input bit dp);
    logic [7:0] s;
    case (dig)
      0: s = 8'hC0; 1: s = 8'hF9; 2: s = 8'hA4; 3: s = 8'hB0; 4: s = 8'h99;
      5: s = 8'h92; 6: s = 8'h82; 7: s = 8'hF8; 8: s = 8'h80; 9: s = 8'h90;
      default: s = 8'hFF;
    endcase
    if (dp) s = s & 8'h7F;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid_o pulse is matched against the scoreboard
  always @(negedge clock) begin
    if (reset && valid_o) begin
      valid_seen++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got bcd %0h expected no pulse", bcd_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd_o", bcd_o, e.bcd);
        chk("ovf_o", ovf_o, e.ovf);
      end
    end
  end

  // Present a value; if it differs from the model snapshot expect a conversion
  task automatic convert(input int v);
    int n;
    @(negedge clock);
    count_i = 16'(v);
    if (v == model_snap) begin
      repeat (3) @(negedge clock);
      chk("no_conv_busy", busy_o, 0);
    end else begin
      model_snap = v;
      sb.push_back('{model_bcd(v), (v >= 10000)});
      @(negedge clock);
      chk("busy_start", busy_o, 1);
      n = 1;
      while (!valid_o && n < 100) begin
        @(negedge clock);
        n++;
      end
      chk("latency", n, IN_W + 2);
      @(negedge clock);
      chk("busy_end", busy_o, 0);
    end
  endtask

  // Watch the scan: one anode low, matching glyph, in order, SCAN_DIV dwell
  task automatic scan_chk(input logic [15:0] bcd, input int cycles);
    int prev, run, runs, d;
    prev = -1; run = 0; runs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      d = -1;
      for (int j = 0; j < DIGITS; j++) if (!an_o[j]) d = j;
      chk("an_onehot", $countones(~an_o), 1);
      if (d >= 0)
        chk("seg_o", seg_o, model_seg(int'(bcd[d*4 +: 4]), d == DP_POS));
      if (d == prev) run++;
      else begin
        if (prev >= 0) chk("scan_order", d, (prev + 1) % DIGITS);
        if (runs > 0) chk("scan_dwell", run, SCAN_DIV);
        runs++;
        run = 1;
      end
      prev = d;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    // 1: reset state
    #12;
    chk("rst_bcd", bcd_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_an", an_o, 4'b1110);
    chk("rst_seg", seg_o, 8'hC0);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("idle_zero_busy", busy_o, 0);

    // 2, 6: main conversion and scan
    convert(1234);
    scan_chk(16'h1234, 40);

    // 3: boundaries
    convert(9999);
    convert(10000);
    convert(65535);
    scan_chk(16'h5535, 24);
    convert(0);

    // 4: mid-conversion change is ignored, then picked up
    base = valid_seen;
    @(negedge clock);
    count_i = 16'd5;
    sb.push_back('{model_bcd(5), 1'b0});
    sb.push_back('{model_bcd(6), 1'b0});
    repeat (3) @(negedge clock);
    count_i = 16'd6;
    model_snap = 6;
    for (int i = 0; i < 100 && valid_seen < base + 2; i++) @(negedge clock);
    repeat (30) @(negedge clock);
    chk("two_pulses", valid_seen - base, 2);

    // 5: reset mid-conversion aborts
    @(negedge clock);
    count_i = 16'd77;
    base = valid_seen;
    repeat (8) @(posedge clock);
    #2;
    chk("busy_before_abort", busy_o, 1);
    reset = 1'b0;
    #1;
    chk("abort_bcd", bcd_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", valid_o, 0);
    chk("abort_ovf", ovf_o, 0);
    chk("abort_an", an_o, 4'b1110);
    chk("abort_seg", seg_o, 8'hC0);
    count_i = 16'd0;
    model_snap = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("abort_no_valid", valid_seen - base, 0);
    chk("post_rst_idle", busy_o, 0);
    convert(42);

    // Randomised values, including a repeat of the last one
    for (int i = 0; i < 12; i++) convert(int'($urandom_range(0, 65535)));
    convert(model_snap);

    repeat (5) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
